alarm_unit: RTL and testbench
=============================

# alarm_unit

Alarm stage downstream of the timer. It consumes the running BCD time and keeps a user-set BCD alarm time (hour/minute) that is exported to a display instance. It drives a RING level for the audio mixer and debounces its own set, snooze and stop buttons. Everything runs on one fast clock, with a one-cycle 1 Hz strobe that advances all second-based counters.

## Interface
- DEBOUNCE_CYC, 200, number of consecutive stable CP cycles needed to accept a button edge (20 ms at 10 kHz)
- RING_SEC, 60, seconds of ringing before automatic stop
- SNOOZE_MIN, 5, snooze length in minutes
- CP  in  1  system clock (10 kHz display clock)
- CR_n  in  1  reset, asynchronous, active-low
- TICK_1HZ  in  1  one-CP-cycle strobe, once per second
- Q_H, Q_M, Q_S  in  8 each  current time, packed BCD; stable on any cycle where TICK_1HZ=1
- AL_EN  in  1  alarm armed (level)
- AL_SET  in  1  alarm-set mode (level)
- AH_UP, AM_UP  in  1 each  raw active-high buttons: alarm hour +1, minute +1
- SNOOZE, STOP  in  1 each  raw active-high buttons
- A_H, A_M  out  8 each  alarm time, packed BCD
- RING  out  1  alarm sounding
- SNOOZING  out  1  snooze interval running

## Operation
- Each raw button passes through a 2-FF synchronizer, then a stable-level counter. The filtered level changes only after DEBOUNCE_CYC consecutive equal samples. A 0->1 change of the filtered level emits a one-cycle press pulse; releases emit nothing.
- Set: while AL_SET=1, an AH_UP press makes A_H +1 BCD, 0x23 wraps to 0x00. An AM_UP press makes A_M +1 BCD, 0x59 wraps to 0x00. Simultaneous presses both apply. No carry from minute into hour. Presses while AL_SET=0 are ignored.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE->RINGING: on a cycle with TICK_1HZ=1, AL_EN=1, AL_SET=0, Q_H==A_H, Q_M==A_M and Q_S==0x00. Clears the tick counter.
- RINGING: each TICK_1HZ increments the tick counter.
  - When the counter reaches RING_SEC -> IDLE.
  - STOP press -> IDLE.
  - SNOOZE press -> SNOOZE, tick counter cleared.
- SNOOZE: each TICK_1HZ increments the tick counter.
  - When it reaches SNOOZE_MIN*60 -> RINGING, counter cleared.
  - STOP press -> IDLE.
- Priority in any state, highest first:
  1. AL_EN=0 or AL_SET=1 -> IDLE.
  2. STOP.
  3. SNOOZE.
  4. Tick expiry.
- A match tick arriving while in SNOOZE or RINGING is ignored.
- Outputs: RING=(state==RINGING); SNOOZING=(state==SNOOZE). Both are registered, decoded from the state register.
- Tick counter is 10 bits and must hold 300; for larger parameters, size it as clog2(max(RING_SEC, SNOOZE_MIN*60)+1).

## Timing
- Reset (CR_n=0, asynchronous):
  - A_H=0x07, A_M=0x00.
  - State IDLE, RING=0, SNOOZING=0.
  - Counters, synchronizers and filtered levels all 0.
- Button latency: 2 sync cycles + DEBOUNCE_CYC stable cycles, then the press pulse. A_H/A_M update on the edge after the pulse.
- Trigger latency: RING rises on the CP edge that samples the matching TICK_1HZ.
- Ring duration: exactly RING_SEC ticks, counted from the tick after the trigger. RING falls on the edge sampling the RING_SEC-th tick.
- Because Q_S=0x00 persists for a single second, each alarm minute triggers at most once.
- Reset asserted mid-ring or mid-snooze: outputs drop immediately (asynchronous). The alarm time is reset to 07:00.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state, SNOOZE debouncer and SNOOZING output behave as above.
- ALARM_SNOOZE_EN undefined:
  - SNOOZE input ignored; its debouncer is not built.
  - SNOOZE state is unreachable; SNOOZING tied to 0.
  - RINGING exits only by STOP, timeout, AL_EN=0 or AL_SET=1.

## Test plan
- Debounce (DEBOUNCE_CYC=4): AL_SET=1, AM_UP bounces 1-0-1 at 1-cycle spacing, then held high for 10 cycles -> exactly one pulse; A_M goes 0x00->0x01.
- Wrap: AL_SET=1; 24 AH_UP presses from 0x07 -> A_H=0x07; A_M preset to 0x59 plus one AM_UP -> 0x00, A_H unchanged.
- Trigger/timeout (RING_SEC=3): A=07:00, AL_EN=1, tick with Q=07:00:00 -> RING=1 next edge; RING=0 on the edge sampling the 3rd following tick. Tick with Q=07:00:01 -> no ring.
- Snooze (SNOOZE_MIN=1, macro defined): ringing, SNOOZE press -> SNOOZING=1, RING=0; after 60 ticks -> RING=1; STOP -> both 0.
- Priority: STOP and SNOOZE pulses in the same cycle while ringing -> IDLE. AL_EN dropped while SNOOZE is active -> IDLE.
- Reset: CR_n pulsed low while RING=1 -> RING=0 without a clock edge; A_H=0x07, A_M=0x00.

Source files
------------

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - BCD alarm time, ring/snooze sequencing and button debouncing.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.

module alarm_unit_debounce #(
   parameter int DEBOUNCE_CYC = 200
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_press
);
   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;
   logic          w_done;

   assign w_done  = (r_cnt == CW'(DEBOUNCE_CYC - 1));
   assign o_press = r_press;

   // r_cnt counts consecutive synchronized samples that disagree with the filtered level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 != r_level) begin
            if (w_done) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
               r_press <= r_sync2;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end
endmodule

module alarm_unit #(
   parameter int DEBOUNCE_CYC = 200,
   parameter int RING_SEC     = 60,
   parameter int SNOOZE_MIN   = 5
) (
   input  logic       CP,
   input  logic       CR_n,
   input  logic       TICK_1HZ,
   input  logic [7:0] Q_H,
   input  logic [7:0] Q_M,
   input  logic [7:0] Q_S,
   input  logic       AL_EN,
   input  logic       AL_SET,
   input  logic       AH_UP,
   input  logic       AM_UP,
   input  logic       SNOOZE,
   input  logic       STOP,
   output logic [7:0] A_H,
   output logic [7:0] A_M,
   output logic       RING,
   output logic       SNOOZING
);
   localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
   localparam int CNT_MAX    = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int CW         = ($clog2(CNT_MAX + 1) > 10) ? $clog2(CNT_MAX + 1) : 10;

   typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_tick_cnt;
   logic [CW-1:0] w_tick_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic [7:0]    r_a_h;
   logic [7:0]    r_a_m;
   logic          w_ah_press;
   logic          w_am_press;
   logic          w_stop_press;
   logic          w_snooze_press;
   logic          w_match;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   alarm_unit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ah (
      .i_clk(CP), .i_rst_n(CR_n), .i_raw(AH_UP), .o_press(w_ah_press));
   alarm_unit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_am (
      .i_clk(CP), .i_rst_n(CR_n), .i_raw(AM_UP), .o_press(w_am_press));
   alarm_unit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (
      .i_clk(CP), .i_rst_n(CR_n), .i_raw(STOP), .o_press(w_stop_press));

`ifdef ALARM_SNOOZE_EN
   alarm_unit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_snooze (
      .i_clk(CP), .i_rst_n(CR_n), .i_raw(SNOOZE), .o_press(w_snooze_press));
   assign SNOOZING = (r_state == S_SNOOZE);
`else
   logic w_unused_snooze;
   assign w_unused_snooze = SNOOZE;
   assign w_snooze_press  = 1'b0;
   assign SNOOZING        = 1'b0;
`endif

   assign RING = (r_state == S_RINGING);
   assign A_H  = r_a_h;
   assign A_M  = r_a_m;

   always_ff @(posedge CP or negedge CR_n) begin
      if (!CR_n) begin
         r_a_h <= 8'h07;
         r_a_m <= 8'h00;
      end else if (AL_SET) begin
         if (w_ah_press)
            r_a_h <= bcd_inc(r_a_h, 8'h23);
         if (w_am_press)
            r_a_m <= bcd_inc(r_a_m, 8'h59);
      end
   end

   assign w_match   = TICK_1HZ && (Q_H == r_a_h) && (Q_M == r_a_m) && (Q_S == 8'h00);
   assign w_cnt_inc = r_tick_cnt + 1'b1;

   always_ff @(posedge CP or negedge CR_n) begin
      if (!CR_n) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
      end
   end

   // Disarm/set-mode wins over everything, then STOP, then SNOOZE, then tick expiry
   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt;
      if (!AL_EN || AL_SET) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_match) begin
                  w_state_nxt    = S_RINGING;
                  w_tick_cnt_nxt = '0;
               end
            end
            S_RINGING: begin
               if (w_stop_press) begin
                  w_state_nxt = S_IDLE;
               end else if (w_snooze_press) begin
                  w_state_nxt    = S_SNOOZE;
                  w_tick_cnt_nxt = '0;
               end else if (TICK_1HZ) begin
                  w_tick_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CW'(RING_SEC))
                     w_state_nxt = S_IDLE;
               end
            end
            S_SNOOZE: begin
               if (w_stop_press) begin
                  w_state_nxt = S_IDLE;
               end else if (TICK_1HZ) begin
                  w_tick_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CW'(SNOOZE_SEC)) begin
                     w_state_nxt    = S_RINGING;
                     w_tick_cnt_nxt = '0;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - self-checking bench for alarm_unit with a cycle-level reference model.
// Snooze checks follow ALARM_SNOOZE_EN.

module tb_alarm_unit;
   localparam int DEB  = 4;
   localparam int RSEC = 3;
   localparam int SMIN = 1;

   logic       CP = 1'b0;
   logic       CR_n = 1'b0;
   logic       TICK_1HZ = 1'b0;
   logic [7:0] Q_H = 8'h00;
   logic [7:0] Q_M = 8'h00;
   logic [7:0] Q_S = 8'h00;
   logic       AL_EN = 1'b0;
   logic       AL_SET = 1'b0;
   logic       AH_UP = 1'b0;
   logic       AM_UP = 1'b0;
   logic       SNOOZE = 1'b0;
   logic       STOP = 1'b0;
   logic [7:0] A_H;
   logic [7:0] A_M;
   logic       RING;
   logic       SNOOZING;

   int total = 0;
   int bad   = 0;

   alarm_unit #(.DEBOUNCE_CYC(DEB), .RING_SEC(RSEC), .SNOOZE_MIN(SMIN)) dut (
      .CP(CP), .CR_n(CR_n), .TICK_1HZ(TICK_1HZ),
      .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
      .AL_EN(AL_EN), .AL_SET(AL_SET),
      .AH_UP(AH_UP), .AM_UP(AM_UP), .SNOOZE(SNOOZE), .STOP(STOP),
      .A_H(A_H), .A_M(A_M), .RING(RING), .SNOOZING(SNOOZING));

   always #5 CP = ~CP;

   function automatic logic [7:0] bcd(input int x);
      return 8'(((x / 10) * 16) + (x % 10));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: integer alarm time, mode 0=idle 1=ringing 2=snoozing.
   // A button is accepted once DEB consecutive raw samples, seen two edges late, oppose its level.
   int          m_ah, m_am, m_st, m_cnt;
   bit          m_lvl [4];
   bit          m_prs [4];
   logic [15:0] m_hist [4];
   logic [3:0]  m_raw;
   bit          m_stop_p, m_snz_p, m_match, m_all;

   always @(posedge CP or negedge CR_n) begin
      if (!CR_n) begin
         m_ah = 7; m_am = 0; m_st = 0; m_cnt = 0;
         for (int b = 0; b < 4; b++) begin
            m_lvl[b] = 0; m_prs[b] = 0; m_hist[b] = '0;
         end
      end else begin
         m_raw    = {STOP, SNOOZE, AM_UP, AH_UP};
         m_stop_p = m_prs[3];
`ifdef ALARM_SNOOZE_EN
         m_snz_p  = m_prs[2];
`else
         m_snz_p  = 0;
`endif
         m_match = TICK_1HZ && Q_H == bcd(m_ah) && Q_M == bcd(m_am) && Q_S == 8'h00;
         if (!AL_EN || AL_SET) m_st = 0;
         else if (m_st == 0) begin
            if (m_match) begin m_st = 1; m_cnt = 0; end
         end
         else if (m_stop_p) m_st = 0;
         else if (m_st == 1 && m_snz_p) begin m_st = 2; m_cnt = 0; end
         else if (TICK_1HZ) begin
            m_cnt++;
            if (m_st == 1 && m_cnt == RSEC) m_st = 0;
            else if (m_st == 2 && m_cnt == SMIN * 60) begin m_st = 1; m_cnt = 0; end
         end
         if (AL_SET) begin
            if (m_prs[0]) m_ah = (m_ah + 1) % 24;
            if (m_prs[1]) m_am = (m_am + 1) % 60;
         end
         for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][14:0], m_raw[b]};
            m_all = 1;
            for (int k = 2; k < DEB + 2; k++)
               if (m_hist[b][k] == m_lvl[b]) m_all = 0;
            m_prs[b] = 0;
            if (m_all) begin
               m_lvl[b] = !m_lvl[b];
               m_prs[b] = m_lvl[b];
            end
         end
      end
   end

   always @(posedge CP) begin
      #1;
      check("cyc_ring", RING, m_st == 1);
      check("cyc_snoozing", SNOOZING, m_st == 2);
      check("cyc_a_h", A_H, bcd(m_ah));
      check("cyc_a_m", A_M, bcd(m_am));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CP);
   endtask

   task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      @(negedge CP);
      Q_H = h; Q_M = m; Q_S = s; TICK_1HZ = 1'b1;
      @(negedge CP);
      TICK_1HZ = 1'b0;
   endtask

   // mask bits: 0 AH_UP, 1 AM_UP, 2 SNOOZE, 3 STOP
   task automatic press(input logic [3:0] mask);
      @(negedge CP);
      {STOP, SNOOZE, AM_UP, AH_UP} = mask;
      cyc(10);
      {STOP, SNOOZE, AM_UP, AH_UP} = 4'b0000;
      cyc(10);
   endtask

   initial begin
      cyc(2);
      check("reset_a_h", A_H, 8'h07);
      check("reset_a_m", A_M, 8'h00);
      check("reset_ring", RING, 0);
      check("reset_snoozing", SNOOZING, 0);
      CR_n = 1'b1;
      cyc(2);

      AL_SET = 1'b1;
      @(negedge CP); AM_UP = 1'b1;
      @(negedge CP); AM_UP = 1'b0;
      @(negedge CP); AM_UP = 1'b1;
      cyc(10);
      AM_UP = 1'b0;
      cyc(10);
      check("debounce_a_m", A_M, 8'h01);

      repeat (24) press(4'b0001);
      check("wrap_a_h_24", A_H, 8'h07);
      repeat (58) press(4'b0010);
      check("a_m_59", A_M, 8'h59);
      press(4'b0010);
      check("wrap_a_m", A_M, 8'h00);
      check("wrap_a_h_kept", A_H, 8'h07);

      AL_SET = 1'b0;
      press(4'b0001);
      check("set_ignored", A_H, 8'h07);

      AL_EN = 1'b1;
      tick(8'h07, 8'h00, 8'h01);
      check("no_ring_s01", RING, 0);
      tick(8'h08, 8'h00, 8'h00);
      check("no_ring_hour", RING, 0);
      tick(8'h07, 8'h00, 8'h00);
      check("trigger", RING, 1);
      tick(8'h07, 8'h00, 8'h01);
      tick(8'h07, 8'h00, 8'h02);
      check("ring_after_2", RING, 1);
      tick(8'h07, 8'h00, 8'h03);
      check("timeout", RING, 0);

      tick(8'h07, 8'h00, 8'h00);
      check("retrigger", RING, 1);
      press(4'b1000);
      check("stop", RING, 0);

`ifdef ALARM_SNOOZE_EN
      tick(8'h07, 8'h00, 8'h00);
      press(4'b0100);
      check("snooze_on", SNOOZING, 1);
      check("snooze_ring_off", RING, 0);
      repeat (59) tick(8'h07, 8'h00, 8'h00);
      check("snooze_59", SNOOZING, 1);
      tick(8'h07, 8'h00, 8'h00);
      check("snooze_expire_ring", RING, 1);
      check("snooze_expire_sn", SNOOZING, 0);
      press(4'b1000);
      check("snooze_stop_ring", RING, 0);
      check("snooze_stop_sn", SNOOZING, 0);
`else
      tick(8'h07, 8'h00, 8'h00);
      press(4'b0100);
      check("snooze_ignored", RING, 1);
      check("snoozing_tied", SNOOZING, 0);
      press(4'b1000);
      check("stop2", RING, 0);
`endif

      tick(8'h07, 8'h00, 8'h00);
      press(4'b1100);
      check("stop_snooze_ring", RING, 0);
      check("stop_snooze_sn", SNOOZING, 0);

`ifdef ALARM_SNOOZE_EN
      tick(8'h07, 8'h00, 8'h00);
      press(4'b0100);
      check("snooze_again", SNOOZING, 1);
`else
      tick(8'h07, 8'h00, 8'h00);
      check("ring_again", RING, 1);
`endif
      @(negedge CP); AL_EN = 1'b0;
      cyc(1);
      check("disarm_sn", SNOOZING, 0);
      check("disarm_ring", RING, 0);
      AL_EN = 1'b1;

      tick(8'h07, 8'h00, 8'h00);
      check("ring_before_set", RING, 1);
      AL_SET = 1'b1;
      cyc(1);
      check("set_mode_idle", RING, 0);
      press(4'b0010);
      AL_SET = 1'b0;
      check("a_m_01", A_M, 8'h01);

      tick(8'h07, 8'h01, 8'h00);
      check("ring_0701", RING, 1);
      #2 CR_n = 1'b0;
      #1;
      check("async_ring", RING, 0);
      check("async_a_h", A_H, 8'h07);
      check("async_a_m", A_M, 8'h00);
      cyc(1);
      CR_n = 1'b1;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
